rr_arbiter8: RTL and testbench

//  - Round-robin arbiter that shares one resource among 8 requesters.
//  - Picks one requester by rotating priority and holds the grant until that requester releases it.
//  - Produces a 3-bit grant index, then decodes it to a one-hot 8-bit grant bus with a 3-to-8 decoder.
//  - Sits in front of any shared datapath slot (bus, memory port, mux select).

---
 rtl/arb_pkg.sv | 10 +
 rtl/rr_grant_decoder.sv | 12 +
 rtl/rr_arbiter8.sv | 93 +++++++++
 tb/tb_rr_arbiter8.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/rr_grant_decoder.sv
// Combinational 3-to-8 one-hot decoder, all-zero when en is low.
module rr_grant_decoder
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign onehot[i] = en && (idx == IDX_W'(i));
  end
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: 8 requesters, grant held until release or withdrawal.
// Optional forced release after MAX_HOLD cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld,
  output logic             timeout
);
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("rr_arbiter8: MAX_HOLD must be >= 2");
  end

  state_e           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt, idx_nxt, pick;
  logic             to_nxt, rls, force_rls;

  // Lowest offset from ptr wins; descending loop lets it overwrite last.
  always_comb begin
    pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[ptr + IDX_W'(k)]) pick = ptr + IDX_W'(k);
    end
  end

  assign rls = rel || !req[grant_idx];

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HC_W = $clog2(MAX_HOLD);
  logic [HC_W-1:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) hold_cnt <= '0;
    else                      hold_cnt <= hold_cnt + HC_W'(1);
  end

  assign force_rls = (hold_cnt == HC_W'(MAX_HOLD - 1));
`else
  assign force_rls = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = grant_idx;
    ptr_nxt   = ptr;
    to_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          idx_nxt   = pick;
        end
      end
      GRANT: begin
        if (rls || force_rls) begin
          state_nxt = IDLE;
          ptr_nxt   = grant_idx + IDX_W'(1);
          to_nxt    = !rls;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant_idx <= idx_nxt;
      timeout   <= to_nxt;
    end
  end

  assign grant_vld = (state == GRANT);

  rr_grant_decoder u_dec (
    .idx    (grant_idx),
    .en     (grant_vld),
    .onehot (grant)
  );
endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomized and directed bench for rr_arbiter8 against a queue-free rotating-priority model.
module tb_rr_arbiter8;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       rel = 1'b0;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_vld;
  logic       timeout;

  int vectors = 0;
  int errors  = 0;
  bit done    = 1'b0;

  // reference model state
  bit m_vld = 0;
  int m_idx = 0;
  int m_ptr = 0;
  bit m_to  = 0;
  int m_hold = 0;

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rel       (rel),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Advance one edge and move the model by the rules with the inputs seen at that edge.
  task automatic tick();
    bit tmo_en;
`ifdef RR_ARB_TIMEOUT_EN
    tmo_en = 1;
`else
    tmo_en = 0;
`endif
    @(posedge clk);
    m_to = 0;
    if (rst) begin
      m_vld = 0; m_idx = 0; m_ptr = 0; m_hold = 0;
    end else if (!m_vld) begin
      if (req != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (req[(m_ptr + k) % 8]) begin
            m_idx = (m_ptr + k) % 8;
            break;
          end
        end
        m_vld = 1; m_hold = 0;
      end
    end else begin
      if (rel || !req[m_idx]) begin
        m_vld = 0; m_ptr = (m_idx + 1) % 8;
      end else if (tmo_en && m_hold == MH - 1) begin
        m_vld = 0; m_ptr = (m_idx + 1) % 8; m_to = 1;
      end else begin
        m_hold++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req = '0; rel = 0;
    tick();
    rst = 0;
  endtask

  // invariant: grant one-hot or zero, and equal to decode(grant_idx) when valid
  always @(negedge clk) begin
    if (!done && !rst) begin
      vectors++;
      if (!$onehot0(grant)) begin
        errors++;
        $display("FAIL onehot0 grant=%h", grant);
      end
      vectors++;
      if (grant !== (grant_vld ? (8'd1 << grant_idx) : 8'd0)) begin
        errors++;
        $display("FAIL decode grant=%h idx=%0d vld=%b", grant, grant_idx, grant_vld);
      end
    end
  end

  task automatic test_reset();
    rst = 1; req = 8'h00; rel = 0;
    tick();
    vectors++;
    if ({grant, grant_idx, grant_vld, timeout} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state grant=%h idx=%0d vld=%b to=%b want all 0", grant, grant_idx, grant_vld, timeout);
    end
    rst = 0; req = 8'h04;
    tick();
    vectors++;
    if (grant !== 8'h04) begin
      errors++;
      $display("FAIL pre_reset_grant got %h want 04", grant);
    end
    rst = 1;
    tick();
    vectors++;
    if (grant !== 8'h00 || grant_vld !== 1'b0) begin
      errors++;
      $display("FAIL mid_grant_reset grant=%h vld=%b want 00/0", grant, grant_vld);
    end
    rst = 0; req = 8'h84;
    tick();
    vectors++;
    if (grant !== 8'h04 || grant_idx !== 3'd2) begin
      errors++;
      $display("FAIL post_reset_ptr0 grant=%h idx=%0d want 04/2", grant, grant_idx);
    end
  endtask

  task automatic test_rotation();
    int seq[9];
    int got = 0;
    bit prev_vld = 0;
    int prev_idx = 0;
    do_reset();
    req = 8'hFF;
    for (int c = 0; c < 150 && got < 9; c++) begin
      rel = (c % 3 == 2);
      tick();
      if (grant_vld && prev_vld && int'(grant_idx) != prev_idx) begin
        vectors++; errors++;
        $display("FAIL rotation_gap back-to-back idx %0d -> %0d", prev_idx, grant_idx);
      end
      if (grant_vld && !prev_vld) begin
        seq[got] = grant_idx;
        got++;
      end
      prev_vld = grant_vld;
      prev_idx = grant_idx;
    end
    rel = 0;
    vectors++;
    if (got != 9) begin
      errors++;
      $display("FAIL rotation_count got %0d grants want 9", got);
    end
    for (int i = 0; i < got; i++) begin
      vectors++;
      if (seq[i] != i % 8) begin
        errors++;
        $display("FAIL rotation_seq[%0d] got %0d want %0d", i, seq[i], i % 8);
      end
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    req = 8'h20;
    tick();
    rel = 1;
    tick();        // release idx 5 -> ptr 6
    rel = 0; req = 8'h09;
    tick();
    vectors++;
    if (grant_vld !== 1'b1 || grant_idx !== 3'd0) begin
      errors++;
      $display("FAIL wrap_idx got vld=%b idx=%0d want 1/0", grant_vld, grant_idx);
    end
    rel = 1;
    tick();
    rel = 0;
    tick();
    vectors++;
    if (grant_vld !== 1'b1 || grant_idx !== 3'd3) begin
      errors++;
      $display("FAIL skip_idx got vld=%b idx=%0d want 1/3", grant_vld, grant_idx);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 8'h20;
    tick();
    req = 8'h00;   // withdraw, rel low
    tick();
    vectors++;
    if (grant_vld !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_release vld=%b want 0", grant_vld);
    end
    req = 8'hFF;
    tick();
    vectors++;
    if (grant_idx !== 3'd6) begin
      errors++;
      $display("FAIL withdraw_ptr idx=%0d want 6", grant_idx);
    end
    // simultaneous rel and withdrawal on idx 6: a single release, ptr -> 7
    req = 8'h00; rel = 1;
    tick();
    rel = 0;
    tick();
    vectors++;
    if (grant_vld !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL dual_release vld=%b to=%b want 0/0", grant_vld, timeout);
    end
    req = 8'hFF;
    tick();
    vectors++;
    if (grant_idx !== 3'd7) begin
      errors++;
      $display("FAIL dual_release_ptr idx=%0d want 7", grant_idx);
    end
  endtask

  task automatic test_timeout();
    int held = 0;
    int to_cnt = 0;
    do_reset();
    req = 8'h02;
`ifdef RR_ARB_TIMEOUT_EN
    begin
      bit seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
        tick();
        if (grant_vld) held++;
        if (timeout) begin
          seen = 1;
          to_cnt++;
          vectors++;
          if (grant !== 8'h00) begin
            errors++;
            $display("FAIL timeout_grant got %h want 00", grant);
          end
        end
      end
      tick();
      if (timeout) to_cnt++;
      vectors++;
      if (held != MH || to_cnt != 1) begin
        errors++;
        $display("FAIL timeout_hold held=%0d pulses=%0d want %0d/1", held, to_cnt, MH);
      end
    end
`else
    for (int c = 0; c < 120; c++) begin
      tick();
      if (grant == 8'h02 && grant_vld) held++;
      if (timeout) to_cnt++;
    end
    vectors++;
    if (held != 120 || to_cnt != 0) begin
      errors++;
      $display("FAIL hold_forever held=%0d pulses=%0d want 120/0", held, to_cnt);
    end
`endif
    req = 8'h00;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      rel = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) req = 8'h00;
      else if ($urandom_range(0, 3) != 0) req = 8'($urandom) & 8'($urandom);
      tick();
      vectors++;
      if (grant_vld !== m_vld || timeout !== m_to || (m_vld && int'(grant_idx) != m_idx)) begin
        errors++;
        $display("FAIL random c=%0d vld=%b idx=%0d to=%b want vld=%b idx=%0d to=%b",
                 c, grant_vld, grant_idx, timeout, m_vld, m_idx, m_to);
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_withdraw();
    test_timeout();
    test_random();
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
